// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port-read/single-port-write SRAM among N_REQ requesters.
// After reset it writes INIT_VALUE to every line, then grants one access per cycle.
module sram_rr_arbiter #(
  parameter int                    SIZE       = 1024,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    N_REQ      = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   AW         = $clog2(SIZE),
  localparam int                   IW         = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ-1:0][AW-1:0]         req_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             init_done,
  output logic                             sram_wr_en,
  output logic [AW-1:0]                    sram_wr_addr,
  output logic [DATA_WIDTH-1:0]            sram_wr_data,
  output logic [AW-1:0]                    sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]            sram_rd_data
);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);

  state_e                  state_q;
  logic [AW-1:0]           cnt_q;
  logic [IW-1:0]           ptr_q;
  logic [IW-1:0]           ptr_d;
  logic [N_REQ-1:0]        rsp_valid_q;
  logic [N_REQ-1:0]        rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    init_done_q;

  logic [IW-1:0]           winner;
  logic [IW:0]             scan;
  logic                    found;
  logic                    grant;

  // Scan ptr, ptr+1, ... (mod N_REQ); the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= NREQ_W) begin
        scan = scan - NREQ_W;
      end
      if (!found && req_valid[scan[IW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IW-1:0];
      end
    end
  end

  assign grant       = found && (state_q == RUN) && !rst;
  assign ptr_d       = (winner == IW'(N_REQ-1)) ? '0 : winner + IW'(1);
  assign rsp_valid_d = N_REQ'(1) << winner;

  // SRAM and handshake drive; everything is held at zero while rst is high.
  always_comb begin
    req_ready    = '0;
    sram_wr_en   = 1'b0;
    sram_wr_addr = '0;
    sram_wr_data = '0;
    sram_rd_addr = '0;
    if (!rst) begin
      if (state_q == INIT) begin
        sram_wr_en   = 1'b1;
        sram_wr_addr = cnt_q;
        sram_wr_data = INIT_VALUE;
      end else if (grant) begin
        req_ready[winner] = 1'b1;
        if (req_we[winner]) begin
          sram_wr_en   = 1'b1;
          sram_wr_addr = req_addr[winner];
          sram_wr_data = req_wdata[winner];
        end else begin
          sram_rd_addr = req_addr[winner];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        INIT: begin
          if (cnt_q == AW'(SIZE-1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        RUN: begin
          if (grant) begin
            ptr_q <= ptr_d;
            // Read data is captured from the combinational SRAM port in the grant cycle.
            if (!req_we[winner]) begin
              rsp_valid_q <= rsp_valid_d;
              rsp_rdata_q <= sram_rd_data;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter: reference arbiter/memory model drives expectations.
module tb_sram_rr_arbiter;

  localparam int NREQ = 3;
  localparam int SIZE = 16;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam logic [DW-1:0] INITV = 8'hA5;

  typedef struct {
    int            cyc;
    int            who;
    logic [DW-1:0] data;
  } rsp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          reqValid;
  logic [NREQ-1:0]          reqWe;
  logic [NREQ-1:0][AW-1:0]  reqAddr;
  logic [NREQ-1:0][DW-1:0]  reqWdata;
  logic [NREQ-1:0]          reqReady;
  logic [NREQ-1:0]          rspValid;
  logic [DW-1:0]            rspRdata;
  logic                     initDone;
  logic                     sramWrEn;
  logic [AW-1:0]            sramWrAddr;
  logic [DW-1:0]            sramWrData;
  logic [AW-1:0]            sramRdAddr;
  logic [DW-1:0]            sramRdData;

  logic [DW-1:0] sramArr [SIZE];
  logic [DW-1:0] refMem  [SIZE];
  rsp_t          sbQ[$];

  int            vecCount    = 0;
  int            errCount    = 0;
  int            cycleNum    = 0;
  int            modelPtr    = 0;
  int            modelCnt    = 0;
  int            lastWinner  = -1;
  bit            modelInit   = 1'b1;
  bit            expInitDone = 1'b0;
  bit            primed      = 1'b0;
  logic [DW-1:0] lastRdata   = '0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .N_REQ(NREQ), .INIT_VALUE(INITV)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_ready(reqReady), .rsp_valid(rspValid), .rsp_rdata(rspRdata), .init_done(initDone),
    .sram_wr_en(sramWrEn), .sram_wr_addr(sramWrAddr), .sram_wr_data(sramWrData),
    .sram_rd_addr(sramRdAddr), .sram_rd_data(sramRdData)
  );

  always @(posedge clk) begin
    if (sramWrEn) sramArr[sramWrAddr] <= sramWrData;
  end
  assign sramRdData = sramArr[sramRdAddr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNum, got, exp);
    end
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One cycle: check last edge's registered outputs, drive inputs, check combinational outputs, advance model.
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                               input logic [NREQ-1:0][AW-1:0] a, input logic [NREQ-1:0][DW-1:0] d);
    int              w;
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] expRsp;
    logic            expWrEn;
    logic [AW-1:0]   expWrAddr;
    logic [AW-1:0]   expRdAddr;
    logic [DW-1:0]   expWrData;
    @(negedge clk);
    if (primed) begin
      if (sbQ.size() > 0 && sbQ[0].cyc == cycleNum - 1) begin
        expRsp = '0;
        expRsp[sbQ[0].who] = 1'b1;
        checkOutput("rsp_valid", 32'(rspValid), 32'(expRsp));
        checkOutput("rsp_rdata", 32'(rspRdata), 32'(sbQ[0].data));
        lastRdata = sbQ[0].data;
        void'(sbQ.pop_front());
      end else begin
        checkOutput("rsp_idle", 32'(rspValid), 32'(0));
        checkOutput("rsp_hold", 32'(rspRdata), 32'(lastRdata));
      end
      checkOutput("init_done", 32'(initDone), 32'(expInitDone));
    end
    rst      = r;
    reqValid = v;
    reqWe    = we;
    reqAddr  = a;
    reqWdata = d;
    #1;
    w         = -1;
    expReady  = '0;
    expWrEn   = 1'b0;
    expWrAddr = '0;
    expWrData = '0;
    expRdAddr = '0;
    if (!r) begin
      if (modelInit) begin
        expWrEn   = 1'b1;
        expWrAddr = AW'(modelCnt);
        expWrData = INITV;
      end else begin
        w = pickWinner(v, modelPtr);
        if (w >= 0) begin
          expReady[w] = 1'b1;
          if (we[w]) begin
            expWrEn   = 1'b1;
            expWrAddr = a[w];
            expWrData = d[w];
          end else begin
            expRdAddr = a[w];
          end
        end
      end
    end
    checkOutput("req_ready", 32'(reqReady), 32'(expReady));
    checkOutput("wr_en", 32'(sramWrEn), 32'(expWrEn));
    checkOutput("wr_addr", 32'(sramWrAddr), 32'(expWrAddr));
    checkOutput("wr_data", 32'(sramWrData), 32'(expWrData));
    checkOutput("rd_addr", 32'(sramRdAddr), 32'(expRdAddr));
    if (r) begin
      modelPtr    = 0;
      modelCnt    = 0;
      modelInit   = 1'b1;
      expInitDone = 1'b0;
      lastRdata   = '0;
      sbQ.delete();
      primed      = 1'b1;
    end else if (modelInit) begin
      refMem[modelCnt] = INITV;
      if (modelCnt == SIZE - 1) begin
        modelInit   = 1'b0;
        expInitDone = 1'b1;
      end else begin
        modelCnt++;
      end
    end else if (w >= 0) begin
      modelPtr = (w + 1) % NREQ;
      if (we[w]) begin
        refMem[a[w]] = d[w];
      end else begin
        sbQ.push_back('{cyc: cycleNum, who: w, data: refMem[a[w]]});
      end
    end
    lastWinner = w;
    cycleNum++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, '0, '0);
  endtask

  logic [NREQ-1:0]         cv;
  logic [NREQ-1:0]         cwe;
  logic [NREQ-1:0][AW-1:0] ca;
  logic [NREQ-1:0][DW-1:0] cd;

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;

    // Reset, INIT pass, then init_done visible.
    applyStimulus(1'b1, '0, '0, '0, '0);
    applyStimulus(1'b1, '0, '0, '0, '0);
    idle(SIZE + 1);

    // Post-init read by req0.
    applyStimulus(1'b0, 3'b001, 3'b000, {4'd0, 4'd0, 4'd7}, '0);
    idle(1);

    // Write-then-read by req1 on consecutive cycles.
    applyStimulus(1'b0, 3'b010, 3'b010, {4'd0, 4'd4, 4'd0}, {8'h00, 8'h3C, 8'h00});
    applyStimulus(1'b0, 3'b010, 3'b000, {4'd0, 4'd4, 4'd0}, '0);
    idle(1);

    // Bring ptr back to 0, then all three requesters valid for 6 cycles.
    applyStimulus(1'b0, 3'b100, 3'b000, {4'd0, 4'd0, 4'd0}, '0);
    applyStimulus(1'b0, 3'b111, 3'b000, {4'd4, 4'd7, 4'd1}, '0);
    applyStimulus(1'b0, 3'b111, 3'b000, {4'd4, 4'd7, 4'd1}, '0);
    applyStimulus(1'b0, 3'b111, 3'b000, {4'd4, 4'd7, 4'd1}, '0);
    applyStimulus(1'b0, 3'b111, 3'b001, {4'd4, 4'd7, 4'd2}, {8'h00, 8'h00, 8'h5E});
    applyStimulus(1'b0, 3'b111, 3'b000, {4'd2, 4'd2, 4'd2}, '0);
    applyStimulus(1'b0, 3'b111, 3'b000, {4'd2, 4'd2, 4'd2}, '0);
    idle(1);

    // ptr=1 with only req0 and req2 valid: grants 2, 0, 2.
    applyStimulus(1'b0, 3'b001, 3'b000, {4'd0, 4'd0, 4'd3}, '0);
    applyStimulus(1'b0, 3'b101, 3'b000, {4'd4, 4'd0, 4'd2}, '0);
    applyStimulus(1'b0, 3'b101, 3'b000, {4'd4, 4'd0, 4'd2}, '0);
    applyStimulus(1'b0, 3'b101, 3'b000, {4'd4, 4'd0, 4'd2}, '0);
    idle(1);

    // Write addr 9, read it, then reset straight after the read grant.
    applyStimulus(1'b0, 3'b100, 3'b100, {4'd9, 4'd0, 4'd0}, {8'h77, 8'h00, 8'h00});
    applyStimulus(1'b0, 3'b001, 3'b000, {4'd0, 4'd0, 4'd9}, '0);
    applyStimulus(1'b1, 3'b111, 3'b111, {4'd9, 4'd9, 4'd9}, {8'h11, 8'h22, 8'h33});
    applyStimulus(1'b1, '0, '0, '0, '0);
    idle(SIZE + 1);
    applyStimulus(1'b0, 3'b010, 3'b000, {4'd0, 4'd9, 4'd0}, '0);
    idle(1);

    // Random traffic; a requester keeps its request stable until granted.
    cv  = '0;
    cwe = '0;
    ca  = '0;
    cd  = '0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cv[i] && $urandom_range(0, 1) == 1) begin
          cv[i]  = 1'b1;
          cwe[i] = 1'($urandom_range(0, 1));
          ca[i]  = AW'($urandom_range(0, SIZE - 1));
          cd[i]  = DW'($urandom);
        end
      end
      applyStimulus(1'b0, cv, cwe, ca, cd);
      if (lastWinner >= 0) cv[lastWinner] = 1'b0;
    end
    idle(2);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
